// File: rtl/cycle_counter.sv
// Up/down counter with clear/load, registered terminal-count flag and wrap pulse.
// Define CYCLE_COUNTER_SATURATE_EN to hold at the end of the range instead of wrapping.
module cycle_counter #(
  parameter int WIDTH    = 6,
  parameter int TERMINAL = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(TERMINAL);
  localparam logic             DONE_RST = (TERMINAL == 0);

  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;
  logic             at_end;

  // at_end: the enabled step would leave the representable range
  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    at_end    = 1'b0;
    if (clr) begin
      count_nxt = '0;
    end else if (load) begin
      count_nxt = load_val;
    end else if (en) begin
      at_end = up ? (count == MAX_VAL) : (count == '0);
`ifdef CYCLE_COUNTER_SATURATE_EN
      if (!at_end) begin
        count_nxt = up ? count + 1'b1 : count - 1'b1;
      end
`else
      count_nxt = up ? count + 1'b1 : count - 1'b1;
      wrap_nxt  = at_end;
`endif
    end
  end

  // done derives from the next-state value so it moves on the same edge as count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      done  <= DONE_RST;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      done  <= (count_nxt == TERM_VAL);
      wrap  <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_cycle_counter.sv
// Directed bench for cycle_counter: default build (WIDTH=6, TERMINAL=32) plus a TERMINAL=0 instance.
module tb_cycle_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic [5:0] load_val = '0;
  logic [5:0] count;
  logic       done;
  logic       wrap;
  logic [5:0] count0;
  logic       done0;
  logic       wrap0;

  int n_assert = 0;
  int n_fail   = 0;

  cycle_counter #(.WIDTH(6), .TERMINAL(32)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count), .done(done), .wrap(wrap)
  );

  cycle_counter #(.WIDTH(6), .TERMINAL(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(count0), .done(done0), .wrap(wrap0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // asynchronous reset, checked before any clock edge
    #1 reset = 1'b0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_done", done, 0);
    chk("rst_done_t0", done0, 1);

    step();
    chk("rst_hold_count", count, 0);

    @(negedge clk);
    reset = 1'b1;
    en = 1'b1;
    up = 1'b1;

    for (int i = 1; i <= 33; i++) begin
      step();
      if (i == 1) begin
        chk("t0_count1", count0, 1);
        chk("t0_done_off", done0, 0);
      end
      if (i == 31) chk("done_before_term", done, 0);
      if (i == 32) begin
        chk("term_count", count, 32);
        chk("term_done", done, 1);
      end
      if (i == 33) begin
        chk("post_term_count", count, 33);
        chk("post_term_done", done, 0);
      end
    end

    for (int i = 34; i <= 64; i++) begin
      step();
      if (i == 63) begin
        chk("top_count", count, 63);
        chk("top_wrap", wrap, 0);
      end
    end
`ifdef CYCLE_COUNTER_SATURATE_EN
    chk("up_sat_count", count, 63);
    chk("up_sat_wrap", wrap, 0);
    step();
    chk("up_sat_hold", count, 63);
`else
    chk("up_wrap_count", count, 0);
    chk("up_wrap_pulse", wrap, 1);
    step();
    chk("up_wrap_next_count", count, 1);
    chk("up_wrap_clears", wrap, 0);
`endif

    // load beats a concurrent enabled step
    load = 1'b1;
    load_val = 6'd45;
    step();
    chk("load_count", count, 45);
    chk("load_wrap", wrap, 0);
    clr = 1'b1;
    step();
    chk("clr_over_load", count, 0);
    chk("clr_wrap", wrap, 0);
    clr = 1'b0;
    load_val = 6'd63;
    step();
    chk("load_max_count", count, 63);
    chk("load_max_wrap", wrap, 0);
    load_val = 6'd32;
    step();
    chk("load_term_done", done, 1);
    load = 1'b0;
    en = 1'b0;
    step();
    chk("hold_count", count, 32);
    chk("hold_done", done, 1);

    // decrement below zero
    clr = 1'b1;
    step();
    chk("clr_done_off", done, 0);
    clr = 1'b0;
    en = 1'b1;
    up = 1'b0;
    step();
`ifdef CYCLE_COUNTER_SATURATE_EN
    chk("dn_sat_count", count, 0);
    chk("dn_sat_wrap", wrap, 0);
`else
    chk("dn_wrap_count", count, 63);
    chk("dn_wrap_pulse", wrap, 1);
`endif
    en = 1'b0;
    step();
    chk("idle_wrap_clear", wrap, 0);

    // saturating/wrapping increment at all-ones
    load = 1'b1;
    load_val = 6'd63;
    step();
    load = 1'b0;
    en = 1'b1;
    up = 1'b1;
    step();
`ifdef CYCLE_COUNTER_SATURATE_EN
    chk("up63_count", count, 63);
    chk("up63_wrap", wrap, 0);
`else
    chk("up63_count", count, 0);
    chk("up63_wrap", wrap, 1);
`endif

    // direction change takes effect on the very next edge
    load = 1'b1;
    load_val = 6'd10;
    step();
    load = 1'b0;
    step();
    chk("dir_up", count, 11);
    up = 1'b0;
    step();
    chk("dir_down", count, 10);
    step();
    chk("dir_down2", count, 9);

    // reset mid-count, between edges
    load = 1'b1;
    load_val = 6'd16;
    up = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("pre_reset_count", count, 17);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_wrap", wrap, 0);
    chk("async_rst_done_t0", done0, 1);
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("post_rst_count", count, 1);
    chk("post_rst_t0_done", done0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
